// File: rtl/hyperbus_rdcap.sv
// HyperBus read-data capture: packs RWDS-qualified DDR beats into 4*WIDTH-bit words and queues them in a FWFT FIFO.
// Optional build macro HBUS_RDCAP_BYTESWAP_EN swaps the two WIDTH-bit halves of every beat before packing.
module hyperbus_rdcap #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk90,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [7:0]           len_i,
    input  logic                 abort_i,
    input  logic [2*WIDTH-1:0]   dq_i,
    input  logic [1:0]           rwds_i,
    output logic [4*WIDTH-1:0]   dat_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 ovf_o,
    output logic                 tmo_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, ERROR} state_t;

    state_t               state;
    logic [7:0]           remaining;
    logic [TW-1:0]        tmo_cnt;
    logic                 half;
    logic [2*WIDTH-1:0]   hold;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic [4*WIDTH-1:0]   mem [DEPTH];

    logic                 beat_vld;
    logic [2*WIDTH-1:0]   beat;
    logic                 pop;
    logic                 full;
    logic                 capturing;
    logic                 completing;
    logic                 push;
    logic                 drop;

    assign beat_vld = (rwds_i == 2'b10);
`ifdef HBUS_RDCAP_BYTESWAP_EN
    assign beat = {dq_i[WIDTH-1:0], dq_i[2*WIDTH-1:WIDTH]};
`else
    assign beat = dq_i;
`endif

    assign valid_o    = (count != '0);
    assign full       = (count == (AW+1)'(DEPTH));
    assign pop        = valid_o && ready_i && !abort_i;
    assign capturing  = ((state == WAIT) || (state == CAPTURE)) && beat_vld && !abort_i;
    assign completing = capturing && half;
    // A full FIFO still accepts the word when the consumer frees a slot in the same cycle.
    assign push       = completing && (!full || pop);
    assign drop       = completing && full && !pop;

    // Unread storage is never exposed: the head reads as zero while empty.
    assign dat_o  = valid_o ? mem[rd_ptr] : '0;
    assign busy_o = (state != IDLE);

    always_ff @(posedge clk90) begin
        if (push) begin
            mem[wr_ptr] <= {hold, beat};
        end
        if (capturing && !half) begin
            hold <= beat;
        end
    end

    always_ff @(posedge clk90 or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            tmo_cnt   <= '0;
            half      <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            done_o    <= 1'b0;
            ovf_o     <= 1'b0;
            tmo_o     <= 1'b0;
        end else if (abort_i) begin
            state     <= IDLE;
            remaining <= '0;
            tmo_cnt   <= '0;
            half      <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            done_o    <= 1'b0;
            ovf_o     <= 1'b0;
            tmo_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (start_i && (len_i != 8'd0)) begin
                        remaining <= len_i;
                        half      <= 1'b0;
                        tmo_cnt   <= TW'(TIMEOUT);
                        state     <= WAIT;
                    end
                end
                WAIT, CAPTURE: begin
                    if (beat_vld) begin
                        tmo_cnt <= TW'(TIMEOUT);
                        state   <= CAPTURE;
                        if (!half) begin
                            half <= 1'b1;
                        end else begin
                            half <= 1'b0;
                            if (drop) begin
                                ovf_o <= 1'b1;
                                state <= ERROR;
                            end else begin
                                remaining <= remaining - 8'd1;
                                if (remaining == 8'd1) begin
                                    done_o <= 1'b1;
                                    state  <= IDLE;
                                end
                            end
                        end
                    end else if (tmo_cnt <= TW'(1)) begin
                        tmo_cnt <= '0;
                        tmo_o   <= 1'b1;
                        state   <= ERROR;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
